// File: rtl/game_cmd_scheduler.sv
// game_cmd_scheduler: merges player key commands, the gravity timer (DOWN) and
// the garbage-bar timer (BAR) into one command stream for the game engine FSM.
// Keys are buffered in a QSIZE-deep FIFO and issued one at a time over a
// valid/ready handshake followed by a cmd_done pulse.
// Build macro HOLD_LOCK_EN: after a HOLD is issued, further HOLD codes are
// discarded at the FIFO head until a DROP completes or flush (one hold per piece).
module game_cmd_scheduler #(
  parameter int unsigned QSIZE     = 16,
  parameter int unsigned MSEC_TICK = 25_000,
  parameter int unsigned DOWN_MS   = 3000,
  parameter int unsigned BAR_TICK  = 500_000_000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     key_valid,
  input  logic [7:0]               key_cmd,
  output logic                     key_ready,
  output logic                     cmd_valid,
  output logic [7:0]               cmd,
  input  logic                     cmd_ready,
  input  logic                     cmd_done,
  output logic                     busy,
  output logic [$clog2(QSIZE):0]   q_count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(QSIZE);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (MSEC_TICK > 1) ? $clog2(MSEC_TICK) : 1;
  localparam int unsigned MW = (DOWN_MS > 1) ? $clog2(DOWN_MS) : 1;
  localparam int unsigned BW = (BAR_TICK > 1) ? $clog2(BAR_TICK) : 1;

  localparam logic [7:0] CODE_NONE       = 8'd0;
  localparam logic [7:0] CODE_LEFT       = 8'd4;
  localparam logic [7:0] CODE_DOWN       = 8'd6;
  localparam logic [7:0] CODE_DROP       = 8'd7;
  localparam logic [7:0] CODE_ROTATE_REV = 8'd10;
  localparam logic [7:0] CODE_BAR        = 8'd11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t          state, state_next;

  logic [7:0]      mem [QSIZE];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      head;
  logic            full, empty, legal, push;

  logic [PW-1:0]   presc;
  logic [MW-1:0]   ms_cnt;
  logic [BW-1:0]   bar_cnt;
  logic            down_pend, bar_pend;
  logic            ms_tick, down_expire, bar_expire, gravity_clr;

  logic            load, pop, accept, finish, withdraw, clr_bar, hold_skip;
  logic [7:0]      load_code;

  assign head      = mem[rd_ptr];
  assign full      = (q_count == CW'(QSIZE));
  assign empty     = (q_count == '0);
  assign key_ready = !full;
  assign legal     = (key_cmd >= CODE_LEFT) && (key_cmd <= CODE_ROTATE_REV);
  assign push      = key_valid && key_ready && legal && !flush;

  assign ms_tick     = enable && (presc == PW'(MSEC_TICK - 1));
  assign down_expire = ms_tick && (ms_cnt == MW'(DOWN_MS - 1));
  assign bar_expire  = enable && (bar_cnt == BW'(BAR_TICK - 1));
  assign gravity_clr = finish && ((cmd == CODE_DOWN) || (cmd == CODE_DROP));

`ifdef HOLD_LOCK_EN
  localparam logic [7:0] CODE_HOLD = 8'd8;
  logic hold_lock;

  // Hold lock: armed by issuing a HOLD, released by a completed DROP or flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            hold_lock <= 1'b0;
    else if (flush)                          hold_lock <= 1'b0;
    else if (finish && (cmd == CODE_DROP))   hold_lock <= 1'b0;
    else if (load && (load_code == CODE_HOLD)) hold_lock <= 1'b1;
  end

  assign hold_skip = hold_lock && (head == CODE_HOLD);
`else
  assign hold_skip = 1'b0;
`endif

  // FIFO storage write (contents need no reset; occupancy is tracked separately)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= key_cmd;
  end

  // FIFO pointers and occupancy; flush wins over a same-cycle push/pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Sticky overflow: key offered while full, or an illegal key code
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          overflow <= 1'b0;
    else if (flush)                        overflow <= 1'b0;
    else if (key_valid && (full || !legal)) overflow <= 1'b1;
  end

  // Gravity timer: ms prescaler and ms counter, restarted by a completed DOWN/DROP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc     <= '0;
      ms_cnt    <= '0;
      down_pend <= 1'b0;
    end else if (flush || gravity_clr) begin
      presc     <= '0;
      ms_cnt    <= '0;
      down_pend <= 1'b0;
    end else if (enable) begin
      if (ms_tick) begin
        presc  <= '0;
        ms_cnt <= down_expire ? '0 : ms_cnt + MW'(1);
      end else begin
        presc  <= presc + PW'(1);
      end
      if (down_expire) down_pend <= 1'b1;
    end
  end

  // Garbage-bar timer; a fresh expiry outranks the clear from issuing BAR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_cnt  <= '0;
      bar_pend <= 1'b0;
    end else if (flush) begin
      bar_cnt  <= '0;
      bar_pend <= 1'b0;
    end else begin
      if (enable) bar_cnt <= bar_expire ? '0 : bar_cnt + BW'(1);
      if (bar_expire)   bar_pend <= 1'b1;
      else if (clr_bar) bar_pend <= 1'b0;
    end
  end

  // Scheduler state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and control strobes; selection priority bar > down > FIFO head
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_code  = CODE_NONE;
    pop        = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    withdraw   = 1'b0;
    clr_bar    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !flush) begin
          if (bar_pend) begin
            load       = 1'b1;
            load_code  = CODE_BAR;
            clr_bar    = 1'b1;
            state_next = ISSUE;
          end else if (down_pend) begin
            load       = 1'b1;
            load_code  = CODE_DOWN;
            state_next = ISSUE;
          end else if (!empty) begin
            pop = 1'b1;
            if (!hold_skip) begin
              load       = 1'b1;
              load_code  = head;
              state_next = ISSUE;
            end
          end
        end
      end
      ISSUE: begin
        if (flush) begin
          withdraw   = 1'b1;
          state_next = IDLE;
        end else if (cmd_ready) begin
          accept     = 1'b1;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (cmd_done) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command output registers driven by the scheduler strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd       <= CODE_NONE;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (load) begin
      cmd       <= load_code;
      cmd_valid <= 1'b1;
    end else if (accept) begin
      cmd_valid <= 1'b0;
      busy      <= 1'b1;
    end else if (withdraw) begin
      cmd_valid <= 1'b0;
      cmd       <= CODE_NONE;
    end else if (finish) begin
      busy      <= 1'b0;
      cmd       <= CODE_NONE;
    end
  end

endmodule

// File: tb/tb_game_cmd_scheduler.sv
// Scoreboard bench for game_cmd_scheduler: stimulus pushes expected command codes,
// a monitor/engine process compares each accepted command and answers with cmd_done.
module tb_game_cmd_scheduler;

  logic       clk = 1'b0;
  logic       reset_n, enable, flush, key_valid, cmd_ready, cmd_done;
  logic [7:0] key_cmd;
  logic       key_ready, cmd_valid, busy, overflow;
  logic [7:0] cmd;
  logic [2:0] q_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_edge = 0;
  logic [7:0] expq [$];

  game_cmd_scheduler #(
    .QSIZE(4), .MSEC_TICK(2), .DOWN_MS(5), .BAR_TICK(40)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .key_valid(key_valid), .key_cmd(key_cmd), .key_ready(key_ready),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .busy(busy), .q_count(q_count), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Monitor + engine model: compare each accepted command, then pulse cmd_done
  initial begin
    logic [7:0] e;
    cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && cmd_valid && cmd_ready && !flush) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cmd: got %0d, expected none", cmd);
        end else begin
          e = expq.pop_front();
          check("issue_order", 32'(cmd), 32'(e));
        end
        @(posedge clk);
        #1 cmd_done = 1'b1;
        done_edge = cyc + 1;
        @(posedge clk);
        #1 cmd_done = 1'b0;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_key(input logic [7:0] code);
    key_valid = 1'b1;
    key_cmd   = code;
    sync();
    key_valid = 1'b0;
    key_cmd   = '0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    sync();
    flush = 1'b0;
  endtask

  // Returns the cycle index of the next rising cmd_valid, or -1 on timeout
  task automatic wait_valid(input int limit, output int at);
    int n;
    n  = 0;
    at = -1;
    do begin @(negedge clk); n++; end while (cmd_valid && n < limit);
    while (!cmd_valid && n < limit) begin @(negedge clk); n++; end
    if (cmd_valid) at = cyc;
    else begin
      checks++;
      failures++;
      $display("FAIL wait_valid_timeout: got no cmd_valid, expected one within %0d cycles", limit);
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(expq.size() == 0 && !busy && !cmd_valid) && n < limit);
    check("idle_reached", 32'(expq.size() == 0 && !busy && !cmd_valid), 32'd1);
    sync();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, t, t_drop;
    reset_n = 1'b0; enable = 1'b1; flush = 1'b0;
    key_valid = 1'b0; key_cmd = '0; cmd_ready = 1'b1;

    // Reset values
    sync(); sync();
    check("rst_key_ready", 32'(key_ready), 32'd1);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd",       32'(cmd),       32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_q_count",   32'(q_count),   32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);

    // Timers from reset: DOWN every gravity period, BAR at bar period (+1 registration cycle)
    expq.push_back(8'd6); expq.push_back(8'd6); expq.push_back(8'd6); expq.push_back(8'd11);
    sync();
    reset_n = 1'b1;
    r = cyc;
    wait_valid(40, t);
    check("first_down_cycle", 32'(t - r), 32'd11);
    wait_valid(40, t);
    wait_valid(40, t);
    wait_valid(40, t);
    check("first_bar_cycle", 32'(t - r), 32'd41);
    wait_idle(20);
    check("cmd_none_after_done", 32'(cmd), 32'd0);
    flush_pulse();

    // Priority: stall a key in ISSUE until bar and down are both pending, keys queued behind
    cmd_ready = 1'b0;
    expq.push_back(8'd10); expq.push_back(8'd11); expq.push_back(8'd6);
    expq.push_back(8'd4);  expq.push_back(8'd5);  expq.push_back(8'd9);
    expq.push_back(8'd6);
    push_key(8'd10); push_key(8'd4); push_key(8'd5); push_key(8'd9);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(cmd_valid), 32'd1);
      check("stall_cmd",   32'(cmd),       32'd10);
    end
    check("stall_q_count", 32'(q_count), 32'd3);
    sync();
    repeat (40) sync();
    cmd_ready = 1'b1;
    wait_idle(60);

    // Full FIFO and overflow (issue blocked with enable low)
    enable = 1'b0; cmd_ready = 1'b0;
    flush_pulse();
    push_key(8'd4); push_key(8'd5); push_key(8'd9); push_key(8'd10);
    check("full_q_count",   32'(q_count),   32'd4);
    check("full_key_ready", 32'(key_ready), 32'd0);
    check("full_no_ovf",    32'(overflow),  32'd0);
    push_key(8'd7);
    check("drop_overflow",  32'(overflow),  32'd1);
    check("drop_q_count",   32'(q_count),   32'd4);

    // Withdraw by flush while in ISSUE
    enable = 1'b1;
    sync();
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(cmd_valid), 32'd1);
      check("hold_cmd",   32'(cmd),       32'd4);
    end
    sync();
    flush_pulse();
    check("flush_valid",    32'(cmd_valid), 32'd0);
    check("flush_cmd",      32'(cmd),       32'd0);
    check("flush_q_count",  32'(q_count),   32'd0);
    check("flush_overflow", 32'(overflow),  32'd0);
    check("flush_busy",     32'(busy),      32'd0);

    // Illegal codes are rejected and flag overflow
    enable = 1'b0;
    push_key(8'd11);
    check("bar_key_overflow", 32'(overflow), 32'd1);
    check("bar_key_q_count",  32'(q_count),  32'd0);
    flush_pulse();
    push_key(8'd3);
    check("low_key_overflow", 32'(overflow), 32'd1);
    check("low_key_q_count",  32'(q_count),  32'd0);
    flush_pulse();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // DROP completion restarts gravity: 10-cycle period + 1 registration cycle
    expq.push_back(8'd7); expq.push_back(8'd6);
    enable = 1'b1; cmd_ready = 1'b1;
    push_key(8'd7);
    wait_valid(20, t_drop);
    wait_valid(40, t);
    check("down_after_drop", 32'(t - done_edge), 32'd11);
    wait_idle(20);
    enable = 1'b0;
    flush_pulse();

    // HOLD sequence
`ifdef HOLD_LOCK_EN
    expq.push_back(8'd8); expq.push_back(8'd7); expq.push_back(8'd8);
`else
    expq.push_back(8'd8); expq.push_back(8'd8); expq.push_back(8'd7); expq.push_back(8'd8);
`endif
    push_key(8'd8); push_key(8'd8); push_key(8'd7); push_key(8'd8);
    enable = 1'b1;
    wait_idle(60);
    enable = 1'b0;
    check("hold_q_count",  32'(q_count),  32'd0);
    check("hold_overflow", 32'(overflow), 32'd0);
    check("exp_drained",   32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
